// File: rtl/if2_fetch_pkg.sv
// Shared constants for the second fetch stage: bus width, FSM encodings and
// the NOP used to fill the output slot when it holds nothing.
package if2_fetch_pkg;

  localparam int IF2_ID_BUS_W = 65;

  localparam logic [1:0] IF2_IDLE = 2'd0;
  localparam logic [1:0] IF2_WAIT = 2'd1;
  localparam logic [1:0] IF2_DROP = 2'd2;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/if2_out_buf.sv
// One-entry output slot toward ID. Clear beats load, and load beats consume.
// The instruction field falls back to the NOP whenever the slot is cleared.
module if2_out_buf
  import if2_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] RESET_NOP = INST_W'(INST_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic              consume,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0] load_inst,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  logic              valid_r;
  logic [ADDR_W-1:0] pc_r;
  logic [INST_W-1:0] inst_r;

  // Slot register: the PC is left alone on clear; only valid and inst reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= {ADDR_W{1'b0}};
      inst_r  <= RESET_NOP;
    end else if (clear) begin
      valid_r <= 1'b0;
      inst_r  <= RESET_NOP;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      inst_r  <= load_inst;
    end else if (consume) begin
      valid_r <= 1'b0;
    end
  end

  assign out_valid = valid_r;
  assign out_pc    = pc_r;
  assign out_inst  = inst_r;

endmodule

// File: rtl/if2_fetch.sv
// Second fetch stage: issues one instruction-memory request per PC (at most
// one outstanding), captures the response into a one-entry slot for ID.
module if2_fetch
  import if2_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] RESET_NOP = INST_W'(INST_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          IF_IF2_Bus,
  input  logic                       flush,
  input  logic                       stop_all,
  input  logic                       id_ready,
  output logic                       pause_mem,
  output logic                       imem_req_valid,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_resp_valid,
  input  logic [INST_W-1:0]          imem_resp_data,
  output logic                       imem_resp_ready,
  output logic [ADDR_W+INST_W:0]     IF2_ID_Bus
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] req_pc_r;
  logic              slot_free_s;
  logic              resp_hs_s;
  logic              req_hs_s;
  logic              load_s;
  logic              consume_s;
  logic              out_valid_s;
  logic [ADDR_W-1:0] out_pc_s;
  logic [INST_W-1:0] out_inst_s;

  assign slot_free_s     = ~out_valid_s | (id_ready & ~stop_all);
  assign imem_resp_ready = (state_r == IF2_DROP) | ((state_r == IF2_WAIT) & slot_free_s);
  assign resp_hs_s       = imem_resp_valid & imem_resp_ready;

  // A new request may go out in the same cycle the previous response retires.
  assign imem_req_valid  = ~rst & ~stop_all & ~flush & slot_free_s &
                           ((state_r == IF2_IDLE) | ((state_r == IF2_WAIT) & resp_hs_s));
  assign imem_req_addr   = IF_IF2_Bus;
  assign req_hs_s        = imem_req_valid & imem_req_ready;

  // Flush releases IF so it can load the jump target.
  assign pause_mem       = rst | (~req_hs_s & ~flush);

  assign load_s          = (state_r == IF2_WAIT) & resp_hs_s & ~flush;
  assign consume_s       = id_ready & ~stop_all & out_valid_s;

  // Next-state logic for the outstanding-request tracker.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      case (state_r)
        IF2_WAIT, IF2_DROP: state_nxt_s = resp_hs_s ? IF2_IDLE : IF2_DROP;
        default:            state_nxt_s = IF2_IDLE;
      endcase
    end else begin
      case (state_r)
        IF2_IDLE: state_nxt_s = req_hs_s ? IF2_WAIT : IF2_IDLE;
        IF2_WAIT: begin
          if (resp_hs_s) begin
            state_nxt_s = req_hs_s ? IF2_WAIT : IF2_IDLE;
          end else begin
            state_nxt_s = IF2_WAIT;
          end
        end
        IF2_DROP: state_nxt_s = resp_hs_s ? IF2_IDLE : IF2_DROP;
        default:  state_nxt_s = IF2_IDLE;
      endcase
    end
  end

  // State and the PC of the request currently in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IF2_IDLE;
      req_pc_r <= {ADDR_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (req_hs_s) begin
        req_pc_r <= IF_IF2_Bus;
      end
    end
  end

  if2_out_buf #(
    .ADDR_W    (ADDR_W),
    .INST_W    (INST_W),
    .RESET_NOP (RESET_NOP)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .load      (load_s),
    .consume   (consume_s),
    .load_pc   (req_pc_r),
    .load_inst (imem_resp_data),
    .out_valid (out_valid_s),
    .out_pc    (out_pc_s),
    .out_inst  (out_inst_s)
  );

  assign IF2_ID_Bus = {out_valid_s, out_pc_s, out_inst_s};

endmodule

// File: doc/if2_fetch.md
# if2_fetch

Second fetch stage of the npc pipeline. Takes the PC from the IF stage over `IF_IF2_Bus`, issues one instruction-memory request per PC, and captures the returned word into a one-entry output slot toward ID as `IF2_ID_Bus`. Backpressures IF through `pause_mem` and discards in-flight fetches on a taken jump (`flush`). At most one memory request is outstanding at any time.

## Interface
- `ADDR_W`, 32, PC/address width
- `INST_W`, 32, instruction width
- `RESET_NOP`, 32'h00000013, `out_inst` value after reset or flush (addi x0,x0,0)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `IF_IF2_Bus`  in  ADDR_W  current PC from IF
- `flush`  in  1  jump taken this cycle (the `jump_en` bit driven to IF)
- `stop_all`  in  1  global freeze
- `id_ready`  in  1  ID consumes the output slot this cycle
- `pause_mem`  out  1  to IF: hold PC
- `imem_req_valid`  out  1  request valid
- `imem_req_addr`  out  ADDR_W  request address (= `IF_IF2_Bus`)
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  response valid
- `imem_resp_data`  in  INST_W  fetched word
- `imem_resp_ready`  out  1  stage accepts response
- `IF2_ID_Bus`  out  1+ADDR_W+INST_W  {out_valid, out_pc, out_inst}

## Operation
- States: IDLE (none outstanding), WAIT (one outstanding, keep), DROP (one outstanding, discard).
- `slot_free = ~out_valid | (id_ready & ~stop_all)`.
- `resp_hs = imem_resp_valid & imem_resp_ready`; `req_hs = imem_req_valid & imem_req_ready`.
- `imem_resp_ready = (state==DROP) | (state==WAIT & slot_free)`. It is 0 in IDLE, and responses in IDLE are ignored.
- `imem_req_valid = ~rst & ~stop_all & ~flush & slot_free & (state==IDLE | (state==WAIT & resp_hs))`. This is a combinational path from `imem_resp_valid`.
- `pause_mem = ~req_hs & ~flush`. It is forced low on `flush` so IF loads the jump target. It is 1 while `rst`.
- On `req_hs`, latch `req_pc <= IF_IF2_Bus`. Next state is WAIT.
- In WAIT with `resp_hs` and no flush:
  - `out_valid <= 1`, `out_pc <= req_pc`, `out_inst <= imem_resp_data`.
  - Next state is WAIT if `req_hs` is also true, else IDLE.
- In DROP with `resp_hs`: the data is discarded. Next state is IDLE.
- ID consumption (`id_ready & ~stop_all & out_valid`) with no new capture sets `out_valid <= 0`.
- `flush` transitions:
  - `out_valid <= 0` and `out_inst <= RESET_NOP`.
  - IDLE -> IDLE.
  - WAIT without `resp_hs` -> DROP.
  - WAIT with `resp_hs` -> IDLE (data dropped).
  - DROP without `resp_hs` -> DROP.
  - DROP with `resp_hs` -> IDLE.
- `stop_all`: no new request, output slot frozen, and `id_ready` ignored. Any outstanding response is still accepted if `~out_valid` (memory cannot be held).
- Reset, asynchronous and any time (including mid-request): state IDLE, `out_valid=0`, `out_pc=0`, `out_inst=RESET_NOP`, `req_pc=0`. A pending memory response after reset lands in IDLE and is ignored.

## Timing
- Request accepted at cycle t → IF advances PC at the t edge.
- Earliest response is t+1. `IF2_ID_Bus` becomes valid in cycle t+2 (registered).
- Zero-wait memory with continuous `id_ready`: one instruction per cycle after a 2-cycle fill.
- Flush in cycle t: the output slot is invalid from t+1. The first request for the jump target is issued no earlier than t+1, or t+2 if the state is DROP and the response is late.
- `out_valid`, `out_pc` and `out_inst` never change while `out_valid & ~id_ready`, unless `flush` or `rst`.

## Structure
- `defines.vh` gains:
  - `` `IF2_ID_Bus`` (65)
  - `` `IF2_IDLE``/`` `IF2_WAIT``/`` `IF2_DROP`` (2-bit encodings)
  - `` `INST_NOP``
  - `` `IF_IF2_Bus`` is reused as is.
- One sub-module, `if2_out_buf`: the output slot with load/consume/clear controls and the reset NOP value.
- The FSM and handshake logic stay in `if2_fetch`.

## Test plan
- Reset release, PC 0x80000000, zero-wait memory returning 0x00000013/0x00100093, `id_ready=1`:
  - `IF2_ID_Bus` = {1,0x80000000,0x13} in cycle 2, then {1,0x80000004,0x00100093}.
  - `pause_mem` stays 0.
- `imem_req_ready=0` for 3 cycles: `pause_mem=1` for those 3 cycles, the PC does not advance, and `imem_req_addr` is stable.
- `id_ready=0` with slot full: `imem_resp_ready=0`, no new request, `pause_mem=1`, and the output is unchanged until `id_ready=1`.
- `flush` while WAIT, response arriving 2 cycles later with 0xDEADBEEF:
  - 0xDEADBEEF never appears on the bus.
  - `out_valid=0` from the flush+1 cycle.
  - The next valid `out_pc` equals the jump target.
- `flush` in the same cycle as `resp_hs`: the response is dropped, the state goes to IDLE, and `pause_mem=0` that cycle.
- `rst` asserted mid-WAIT, deasserted 1 cycle later:
  - Outputs immediately go to {0,0,0x13}.
  - The late response is ignored (`imem_resp_ready=0`).
  - Fetch restarts from the IF reset PC.
